// File: rtl/soc_mem_pkg.sv
// Shared types and widths for the core memory arbiter slice.
package soc_mem_pkg;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } src_e;

   localparam int unsigned MEM_DATA_W = 32;
   localparam int unsigned MEM_BE_W   = 4;

endpackage

// File: rtl/core_mem_id_fifo.sv
// Response-routing FIFO: remembers which port owns each outstanding memory transfer.
module core_mem_id_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == CNT_W'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign dout   = r_mem[r_rptr];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= din;
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter merging the instruction and data ports onto one OBI memory port,
// with in-order response steering through an ID FIFO.
module core_mem_arbiter
   import soc_mem_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned ADDR_W          = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  instr_req,
   input  logic [ADDR_W-1:0]     instr_addr,
   output logic                  instr_gnt,
   output logic                  instr_rvalid,
   output logic [MEM_DATA_W-1:0] instr_rdata,
   input  logic                  data_req,
   input  logic [ADDR_W-1:0]     data_addr,
   input  logic                  data_we,
   input  logic [MEM_BE_W-1:0]   data_be,
   input  logic [MEM_DATA_W-1:0] data_wdata,
   output logic                  data_gnt,
   output logic                  data_rvalid,
   output logic [MEM_DATA_W-1:0] data_rdata,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [MEM_BE_W-1:0]   mem_be,
   output logic [MEM_DATA_W-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [MEM_DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   src_e             r_last_grant;
   logic             err_q;
   src_e             w_sel;
   logic             w_full;
   logic             w_empty;
   logic             w_hs;
   logic             w_pop;
   logic [0:0]       w_head;
   logic [CNT_W-1:0] w_count_unused;

   always_comb begin
      w_sel = (r_last_grant == SRC_DATA) ? SRC_INSTR : SRC_DATA;
      if (instr_req && !data_req)      w_sel = SRC_INSTR;
      else if (data_req && !instr_req) w_sel = SRC_DATA;
   end

   assign mem_req   = (instr_req | data_req) & ~w_full;
   assign mem_addr  = (w_sel == SRC_DATA) ? data_addr  : instr_addr;
   assign mem_we    = (w_sel == SRC_DATA) ? data_we    : 1'b0;
   assign mem_be    = (w_sel == SRC_DATA) ? data_be    : 4'hF;
   assign mem_wdata = (w_sel == SRC_DATA) ? data_wdata : 32'h0;

   // Gating with rst_i keeps handshakes and responses silent while reset is held.
   assign w_hs      = mem_req & mem_gnt & ~rst_i;
   assign w_pop     = mem_rvalid & ~w_empty & ~rst_i;
   assign instr_gnt = w_hs & (w_sel == SRC_INSTR);
   assign data_gnt  = w_hs & (w_sel == SRC_DATA);

   assign instr_rvalid = w_pop & (src_e'(w_head) == SRC_INSTR);
   assign data_rvalid  = w_pop & (src_e'(w_head) == SRC_DATA);
   assign instr_rdata  = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_grant <= SRC_DATA;
         err_q        <= 1'b0;
      end else begin
         if (w_hs) r_last_grant <= w_sel;
         // Response with nothing outstanding: sticky protocol error.
         err_q <= err_q | (mem_rvalid & w_empty);
      end
   end

   core_mem_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (w_hs),
      .din   (w_sel),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count_unused)
   );

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- MAX_OUTSTANDING, default 2: depth of the response-routing FIFO, power of two, >=2.
- ADDR_W, default 32: address width.
REQ-002 Ports SHALL be, clock and reset first, one per line:
- clk_i  in  1  single system clock.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req  in  1  instruction-port request (CORE_INST_INF Slave side).
- instr_addr  in  ADDR_W  instruction address.
- instr_gnt  out  1  instruction request accepted.
- instr_rvalid  out  1  instruction read data valid.
- instr_rdata  out  32  instruction read data.
- data_req  in  1  data-port request (CORE_DATA_INF Slave side).
- data_addr  in  ADDR_W  data address.
- data_we  in  1  data write enable.
- data_be  in  4  data byte enables.
- data_wdata  in  32  data write data.
- data_gnt  out  1  data request accepted.
- data_rvalid  out  1  data response valid (reads and writes).
- data_rdata  out  32  data read data.
- mem_req, mem_addr, mem_we, mem_be, mem_wdata  out  1/ADDR_W/1/4/32  shared memory request.
- mem_gnt  in  1  memory accepted request.
- mem_rvalid  in  1  memory response valid, in order.
- mem_rdata  in  32  memory read data.

Function
REQ-003 Handshake SHALL be OBI-style: a transfer completes in the cycle where req=1 and gnt=1. A requester holds req/addr/we/be/wdata stable until granted. Exactly one rvalid returns per granted transfer, in grant order.
REQ-004 Arbitration SHALL be combinational. sel = DATA if only data_req; INSTR if only instr_req; if both, the port opposite to last_grant (round-robin).
REQ-005 mem_req SHALL = (instr_req | data_req) & ~fifo_full. mem_* payload SHALL come from the selected port.
REQ-006 When INSTR is selected: mem_we=0, mem_be=4'hF, mem_wdata=32'h0.
REQ-007 <port>_gnt SHALL = mem_gnt & mem_req & (sel==<port>). The non-selected gnt SHALL be 0.
REQ-008 last_grant SHALL update to sel only on a completed mem handshake. Its reset value SHALL be DATA, so INSTR wins the first tie.
REQ-009 Each completed handshake SHALL push a 1-bit source ID (0=INSTR, 1=DATA) into the routing FIFO.
REQ-010 Each mem_rvalid SHALL pop the FIFO head and raise the matching <port>_rvalid combinationally in the same cycle.
REQ-011 instr_rdata and data_rdata SHALL both be driven with mem_rdata unconditionally. Only rvalid is steered.
REQ-012 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-013 When count==MAX_OUTSTANDING, mem_req SHALL be forced to 0 and no gnt issued. A pop in that same cycle SHALL NOT unblock the request until the next cycle.
REQ-014 mem_rvalid with an empty FIFO is a protocol error: rvalid outputs stay 0 and the sticky internal flag err_q is set (assertion target).
REQ-015 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING. The count SHALL be $clog2(MAX_OUTSTANDING)+1 bits wide.
REQ-016 Zero added latency: a request is granted in the same cycle mem_gnt is asserted.

Reset
REQ-017 On rst_i=1, asynchronously:
- FIFO pointers and count SHALL clear to 0.
- last_grant SHALL be DATA.
- err_q SHALL be 0.
- All gnt/rvalid outputs SHALL be 0 while reset is asserted.
REQ-018 Reset mid-transaction SHALL discard all outstanding IDs. Responses arriving after reset are treated per REQ-014. Memory is reset by the same rst_i.

Structure
REQ-019 Package soc_mem_pkg SHALL hold:
- enum src_e {SRC_INSTR=1'b0, SRC_DATA=1'b1}.
- Constant MEM_DATA_W=32.
- Constant MEM_BE_W=4.
REQ-020 The routing FIFO SHALL be the sub-module core_mem_id_fifo (parameterised depth and width, push/pop/full/empty/count). The top level holds arbitration and steering only.

Verification
REQ-021 Both requests at the cycle after reset, mem_gnt=1 -> instr_gnt=1 in that cycle. Next cycle data_gnt=1. mem_rvalid on the following two cycles -> instr_rvalid, then data_rvalid.
REQ-022 Both requesters continuously, mem_gnt=1 for 8 cycles -> grants alternate I,D,I,D,I,D,I,D.
REQ-023 MAX_OUTSTANDING=2, mem_rvalid held 0, data_req held -> two grants, then mem_req=0. One mem_rvalid -> data_rvalid=1, and the next cycle mem_req=1 with grant.
REQ-024 Data write addr=32'h1000_0004, be=4'b0011, wdata=32'hDEADBEEF -> mem_* mirrors the payload exactly. Instr fetch of addr=32'h80 -> mem_we=0, mem_be=4'hF.
REQ-025 mem_gnt=0 for 3 cycles with both requesting -> no gnt asserted, and the payload stays stable for the selected port.
REQ-026 rst_i pulsed with 2 outstanding, then a stray mem_rvalid -> no rvalid output, err_q=1, and the count stays 0.
